// File: rtl/mapper_pkg.sv
// Shared constants and helpers for the PageRank row mapper.
//   NBITS_DEF/NLANES_DEF/FRAC_DEF/CNTW_DEF : default parameter values
//   clog2   : ceiling log2, sets the adder-tree depth
//   lane_lo : low bit index of a lane inside a packed lane bus
package mapper_pkg;

    localparam int unsigned NBITS_DEF  = 32;
    localparam int unsigned NLANES_DEF = 4;
    localparam int unsigned FRAC_DEF   = 0;
    localparam int unsigned CNTW_DEF   = 16;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned w);
        return lane * w;
    endfunction

endpackage

// File: rtl/mapper_adder_tree.sv
// Combinational binary adder tree, sum modulo 2^nbits.
//   in_terms : NLANES packed terms, lane i at [i*nbits +: nbits]
//   out_sum  : wrap-around sum of all terms
module mapper_adder_tree
    import mapper_pkg::*;
#(
    parameter int unsigned nbits  = NBITS_DEF,
    parameter int unsigned NLANES = NLANES_DEF
) (
    input  logic [NLANES*nbits-1:0] in_terms,
    output logic [nbits-1:0]        out_sum
);

    localparam int unsigned DEPTH = clog2(NLANES);
    localparam int unsigned NNODE = 2 * NLANES - 1;

    // Heap layout: node 0 is the root, children of j are 2j+1 and 2j+2,
    // leaves occupy NLANES-1 .. 2*NLANES-2.
    logic [nbits-1:0] w_node [NNODE];

    for (genvar lf = 0; lf < NLANES; lf++) begin : g_leaf
        assign w_node[NLANES-1+lf] = in_terms[lane_lo(lf, nbits) +: nbits];
    end

    for (genvar lv = 0; lv < DEPTH; lv++) begin : g_level
        for (genvar k = 0; k < (1 << lv); k++) begin : g_node
            localparam int unsigned J = (1 << lv) - 1 + k;
            assign w_node[J] = w_node[2*J+1] + w_node[2*J+2];
        end
    end

    assign out_sum = w_node[0];

endmodule

// File: rtl/pagerank_row_mapper.sv
// Per-row dot product of rank and link-matrix entries, NLANES per beat.
//   clk, reset          : clock, synchronous active-high reset
//   in_val/in_rdy       : input beat handshake (in_rdy combinational)
//   in_r, in_g          : packed lane data, lane i at [i*nbits +: nbits]
//   in_mask             : per-lane enable, masked lanes contribute 0
//   in_last             : final beat of the current row
//   out_val/out_rdy     : row result handshake
//   out_sum, out_beats  : row dot product and saturating beat count
module pagerank_row_mapper
    import mapper_pkg::*;
#(
    parameter int unsigned nbits  = NBITS_DEF,
    parameter int unsigned NLANES = NLANES_DEF,
    parameter int unsigned FRAC   = FRAC_DEF,
    parameter int unsigned CNTW   = CNTW_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_val,
    output logic                    in_rdy,
    input  logic [NLANES*nbits-1:0] in_r,
    input  logic [NLANES*nbits-1:0] in_g,
    input  logic [NLANES-1:0]       in_mask,
    input  logic                    in_last,
    output logic                    out_val,
    input  logic                    out_rdy,
    output logic [nbits-1:0]        out_sum,
    output logic [CNTW-1:0]         out_beats
);

    localparam int unsigned PW = 2 * nbits;

    logic                    w_adv;
    logic [NLANES*nbits-1:0] w_prod;
    logic [nbits-1:0]        w_tree_sum;
    logic [nbits-1:0]        w_acc_next;
    logic [CNTW-1:0]         w_beats_next;

    logic                    r_s1_val;
    logic                    r_s1_last;
    logic [NLANES*nbits-1:0] r_s1_prod;
    logic                    r_s2_val;
    logic                    r_s2_last;
    logic [nbits-1:0]        r_s2_sum;
    logic [nbits-1:0]        r_acc;
    logic [CNTW-1:0]         r_beats;

    // The whole pipeline moves together; it only stalls behind an unaccepted result.
    assign w_adv  = !out_val || out_rdy;
    assign in_rdy = w_adv;

    // Full-width product, scaled by FRAC, truncated back to nbits.
    for (genvar i = 0; i < NLANES; i++) begin : g_lane
        assign w_prod[lane_lo(i, nbits) +: nbits] = in_mask[i]
            ? nbits'((PW'(in_r[lane_lo(i, nbits) +: nbits])
                    * PW'(in_g[lane_lo(i, nbits) +: nbits])) >> FRAC)
            : '0;
    end

    mapper_adder_tree #(
        .nbits  (nbits),
        .NLANES (NLANES)
    ) u_tree (
        .in_terms (r_s1_prod),
        .out_sum  (w_tree_sum)
    );

    assign w_acc_next   = r_acc + r_s2_sum;
    assign w_beats_next = (r_beats == '1) ? r_beats : r_beats + CNTW'(1);

    // Three-stage pipeline: multiply, reduce, accumulate/emit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_val  <= 1'b0;
            r_s1_last <= 1'b0;
            r_s1_prod <= '0;
            r_s2_val  <= 1'b0;
            r_s2_last <= 1'b0;
            r_s2_sum  <= '0;
            r_acc     <= '0;
            r_beats   <= '0;
            out_val   <= 1'b0;
            out_sum   <= '0;
            out_beats <= '0;
        end else if (w_adv) begin
            r_s1_val  <= in_val;
            r_s1_last <= in_last;
            r_s1_prod <= w_prod;
            r_s2_val  <= r_s1_val;
            r_s2_last <= r_s1_last;
            r_s2_sum  <= w_tree_sum;
            out_val   <= r_s2_val && r_s2_last;
            if (r_s2_val) begin
                if (r_s2_last) begin
                    out_sum   <= w_acc_next;
                    out_beats <= w_beats_next;
                    r_acc     <= '0;
                    r_beats   <= '0;
                end else begin
                    r_acc     <= w_acc_next;
                    r_beats   <= w_beats_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_pagerank_row_mapper.sv
// Self-checking bench: three mapper instances (FRAC=0, FRAC=16, CNTW=2)
// share one input stream and are compared against a row-level model.
module tb_pagerank_row_mapper;

    localparam int unsigned NB = 32;
    localparam int unsigned NL = 4;

    logic           clk;
    logic           reset;
    logic           in_val;
    logic [NL*NB-1:0] in_r;
    logic [NL*NB-1:0] in_g;
    logic [NL-1:0]  in_mask;
    logic           in_last;
    logic           out_rdy;

    logic           in_rdy,  in_rdy_fx,  in_rdy_s;
    logic           out_val, out_val_fx, out_val_s;
    logic [NB-1:0]  out_sum, out_sum_fx, out_sum_s;
    logic [15:0]    out_beats, out_beats_fx;
    logic [1:0]     out_beats_s;

    int n_vec = 0;
    int n_mis = 0;

    pagerank_row_mapper #(.nbits(NB), .NLANES(NL), .FRAC(0), .CNTW(16)) dut (
        .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy),
        .in_r(in_r), .in_g(in_g), .in_mask(in_mask), .in_last(in_last),
        .out_val(out_val), .out_rdy(out_rdy), .out_sum(out_sum), .out_beats(out_beats));

    pagerank_row_mapper #(.nbits(NB), .NLANES(NL), .FRAC(16), .CNTW(16)) dut_fx (
        .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy_fx),
        .in_r(in_r), .in_g(in_g), .in_mask(in_mask), .in_last(in_last),
        .out_val(out_val_fx), .out_rdy(out_rdy), .out_sum(out_sum_fx), .out_beats(out_beats_fx));

    pagerank_row_mapper #(.nbits(NB), .NLANES(NL), .FRAC(0), .CNTW(2)) dut_s (
        .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy_s),
        .in_r(in_r), .in_g(in_g), .in_mask(in_mask), .in_last(in_last),
        .out_val(out_val_s), .out_rdy(out_rdy), .out_sum(out_sum_s), .out_beats(out_beats_s));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [NL*NB-1:0] pack4(input logic [31:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    // ---------------- behavioural row model ----------------
    typedef struct {
        logic [31:0] s0;
        logic [31:0] s16;
        int unsigned beats;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_acc0 = 0, m_acc16 = 0;
    int unsigned m_beats = 0;
    logic        stall_prev = 0;
    logic [31:0] prev_sum;
    logic [15:0] prev_beats;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            m_acc0 = 0; m_acc16 = 0; m_beats = 0;
            stall_prev = 0;
        end else begin
            chk("in_rdy", 64'(in_rdy), 64'(!out_val || out_rdy));
            chk("fx_val_align", 64'(out_val_fx), 64'(out_val));
            chk("sat_val_align", 64'(out_val_s), 64'(out_val));
            if (stall_prev) begin
                chk("stall_val", 64'(out_val), 64'd1);
                chk("stall_sum", 64'(out_sum), 64'(prev_sum));
                chk("stall_beats", 64'(out_beats), 64'(prev_beats));
            end
            stall_prev = out_val && !out_rdy;
            prev_sum   = out_sum;
            prev_beats = out_beats;

            if (out_val && out_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_row", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("row_sum", 64'(out_sum), 64'(e.s0));
                    chk("row_sum_frac16", 64'(out_sum_fx), 64'(e.s16));
                    chk("row_beats", 64'(out_beats), 64'((e.beats > 65535) ? 65535 : e.beats));
                    chk("row_beats_sat2", 64'(out_beats_s), 64'((e.beats > 3) ? 3 : e.beats));
                    chk("row_sum_sat_inst", 64'(out_sum_s), 64'(e.s0));
                end
            end

            if (in_val && in_rdy) begin
                logic [63:0] p;
                for (int i = 0; i < NL; i++) begin
                    if (in_mask[i]) begin
                        p = 64'(in_r[i*NB +: NB]) * 64'(in_g[i*NB +: NB]);
                        m_acc0  = m_acc0 + p[31:0];
                        m_acc16 = m_acc16 + p[47:16];
                    end
                end
                m_beats++;
                if (in_last) begin
                    exp_t e;
                    e.s0 = m_acc0; e.s16 = m_acc16; e.beats = m_beats;
                    exp_q.push_back(e);
                    m_acc0 = 0; m_acc16 = 0; m_beats = 0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic rand_rdy = 0;
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    // Present one beat and hold it until accepted; returns at accept edge + 1.
    task automatic send(input logic [NL*NB-1:0] r, g, input logic [NL-1:0] m, input logic l);
        logic acc;
        logic done;
        done = 0;
        in_r = r; in_g = g; in_mask = m; in_last = l; in_val = 1'b1;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            acc = in_rdy;
            @(posedge clk);
            #1;
            if (acc) done = 1;
        end
        in_val = 1'b0;
        if (!done) chk("send_timeout", 64'd1, 64'd0);
    endtask

    // Wait (bounded) for out_val at a falling edge; lat counts edges since the call.
    task automatic wait_out(output int lat);
        lat = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (out_val) return;
            @(posedge clk);
            #1;
            lat++;
        end
        chk("wait_out_timeout", 64'd1, 64'd0);
    endtask

    task automatic realign();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int lat;
        logic [31:0] got [3];
        int ng;

        reset = 1'b1; in_val = 0; in_r = '0; in_g = '0; in_mask = '0; in_last = 0; out_rdy = 1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_out_val", 64'(out_val), 64'd0);
        chk("rst_out_sum", 64'(out_sum), 64'd0);
        chk("rst_out_beats", 64'(out_beats), 64'd0);
        chk("rst_in_rdy", 64'(in_rdy), 64'd1);

        // Single-beat row and its latency (accept edge counts as 1).
        send(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 4'b1111, 1'b1);
        wait_out(lat);
        chk("latency", 64'(lat + 1), 64'd3);
        chk("single_sum", 64'(out_sum), 64'd70);
        chk("single_beats", 64'(out_beats), 64'd1);
        realign();

        // Two-beat row with partial mask, then a row that proves acc was cleared.
        send(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 4'b1111, 1'b0);
        send(pack4(1, 1, 1, 1), pack4(10, 10, 10, 10), 4'b0011, 1'b1);
        wait_out(lat);
        chk("two_beat_sum", 64'(out_sum), 64'd90);
        chk("two_beat_beats", 64'(out_beats), 64'd2);
        realign();
        send(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 4'b1111, 1'b1);
        wait_out(lat);
        chk("acc_cleared_sum", 64'(out_sum), 64'd70);
        realign();

        // Backpressure: three rows queued behind a stalled output.
        out_rdy = 1'b0;
        send(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 4'b1111, 1'b1);
        send(pack4(1, 1, 1, 1), pack4(5, 5, 5, 5), 4'b1111, 1'b1);
        send(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 4'b1111, 1'b1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("bp_in_rdy", 64'(in_rdy), 64'd0);
            chk("bp_sum_hold", 64'(out_sum), 64'd70);
        end
        realign();
        out_rdy = 1'b1;
        ng = 0;
        for (int t = 0; t < 30 && ng < 3; t++) begin
            @(negedge clk);
            if (out_val) begin
                got[ng] = out_sum;
                ng++;
            end
        end
        chk("bp_count", 64'(ng), 64'd3);
        chk("bp_row0", 64'(got[0]), 64'd70);
        chk("bp_row1", 64'(got[1]), 64'd20);
        chk("bp_row2", 64'(got[2]), 64'd4);
        realign();

        // Wrap-around of the lane product and the reduction.
        send(pack4(32'hFFFF_FFFF, 1, 0, 0), pack4(2, 2, 0, 0), 4'b0011, 1'b1);
        wait_out(lat);
        chk("wrap_sum", 64'(out_sum), 64'h0);
        chk("wrap_sum_frac16", 64'(out_sum_fx), 64'h0001_FFFF);
        realign();

        // Fixed point: 1.5 * 2.0 in Q16.16.
        send(pack4(32'h0001_8000, 0, 0, 0), pack4(32'h0002_0000, 0, 0, 0), 4'b0001, 1'b1);
        wait_out(lat);
        chk("frac16_sum", 64'(out_sum_fx), 64'h0003_0000);
        chk("frac0_trunc", 64'(out_sum), 64'h0);
        realign();

        // Five-beat row with an empty-mask beat; beat counter saturates on CNTW=2.
        send(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 4'b1111, 1'b0);
        send(pack4(9, 9, 9, 9), pack4(9, 9, 9, 9), 4'b0000, 1'b0);
        send(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 4'b1111, 1'b0);
        send(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 4'b1111, 1'b0);
        send(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 4'b1111, 1'b1);
        wait_out(lat);
        chk("five_sum", 64'(out_sum), 64'd16);
        chk("five_beats", 64'(out_beats), 64'd5);
        chk("five_beats_sat", 64'(out_beats_s), 64'd3);
        realign();

        // Reset in the middle of a row discards it.
        send(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 4'b1111, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_val_during", 64'(out_val), 64'd0);
        realign();
        reset = 1'b0;
        chk("mid_rst_val", 64'(out_val), 64'd0);
        chk("mid_rst_sum", 64'(out_sum), 64'd0);
        chk("mid_rst_beats", 64'(out_beats), 64'd0);
        send(pack4(1, 1, 1, 1), pack4(5, 5, 5, 5), 4'b1111, 1'b1);
        wait_out(lat);
        chk("post_rst_sum", 64'(out_sum), 64'd20);
        chk("post_rst_beats", 64'(out_beats), 64'd1);
        realign();

        // Random traffic with random output backpressure.
        rand_rdy = 1'b1;
        for (int b = 0; b < 400; b++) begin
            logic [NL*NB-1:0] rr, gg;
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) realign();
            for (int i = 0; i < NL; i++) begin
                rr[i*NB +: NB] = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
                gg[i*NB +: NB] = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            end
            send(rr, gg, 4'($urandom_range(0, 15)), (b == 399) || ($urandom_range(0, 3) == 0));
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #2 out_rdy = 1'b1;
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) realign();
        repeat (3) realign();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
